// File: rtl/call_stack_pkg.sv
// Shared encodings and defaults for the call/return stack controller.
package call_stack_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_PCW   = 13;
    localparam int DEPTH_W       = 4;

    localparam logic [DEFAULT_PCW-1:0] DEFAULT_INT_VECTOR = 13'h0004;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        POP_WAIT = 2'd1,
        LOAD     = 2'd2,
        FAULT    = 2'd3
    } stateT;

    typedef enum logic [1:0] {
        FAULT_NONE      = 2'b00,
        FAULT_OVERFLOW  = 2'b01,
        FAULT_UNDERFLOW = 2'b10
    } faultCodeT;

endpackage

// File: rtl/call_stack_depth.sv
// Saturating stack occupancy counter, 0..DEPTH; inc/dec take effect at the clock edge.
// No backpressure: inc at full and dec at empty are ignored.
module call_stack_depth
    import call_stack_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CW    = DEPTH_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] MAX_COUNT = CW'(DEPTH);

    logic [CW-1:0] countReg;

    assign full  = (countReg == MAX_COUNT);
    assign empty = (countReg == '0);
    assign count = countReg;

    // Simultaneous inc/dec cancel; saturation keeps the count inside 0..DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            countReg <= '0;
        end else if (inc && !dec && !full) begin
            countReg <= countReg + 1'b1;
        end else if (dec && !inc && !empty) begin
            countReg <= countReg - 1'b1;
        end
    end

endmodule

// File: rtl/call_stack_ctrl.sv
// CALL/INT/RET sequencer driving the return-stack RAM and fetch PC load.
// pcLoad 1 cycle after CALL/INT accept, 2 after RET; stall blocks acceptance and holds LOAD.
module call_stack_ctrl
    import call_stack_pkg::*;
#(
    parameter int                   DEPTH      = DEFAULT_DEPTH,
    parameter int                   PCW        = DEFAULT_PCW,
    parameter logic [PCW-1:0]       INT_VECTOR = DEFAULT_INT_VECTOR
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           intReq,
    input  logic           callReq,
    input  logic           retReq,
    input  logic [PCW-1:0] retAddr,
    input  logic [PCW-1:0] callTarget,
    input  logic           stall,
    input  logic           clearFault,
    input  logic [PCW-1:0] stackData,
    output logic           ack,
    output logic           stackPush,
    output logic           stackPop,
    output logic [PCW-1:0] stackPcIn,
    output logic           pcLoad,
    output logic [PCW-1:0] pcTarget,
    output logic           gieClear,
    output logic           busy,
    output logic           stackFault,
    output logic [1:0]     faultCode,
    output logic [3:0]     depth
);

    stateT          state;
    stateT          stateNext;
    logic [PCW-1:0] targetReg;
    logic [PCW-1:0] targetNext;
    logic           targetLoad;
    logic           faultSet;
    logic           faultClr;
    faultCodeT      faultCodeNext;
    faultCodeT      faultCodeReg;
    logic           faultReg;
    logic           depthInc;
    logic           depthDec;
    logic           depthFull;
    logic           depthEmpty;

    call_stack_depth #(
        .DEPTH (DEPTH),
        .CW    (4)
    ) uDepth (
        .clk   (clk),
        .reset (reset),
        .inc   (depthInc),
        .dec   (depthDec),
        .full  (depthFull),
        .empty (depthEmpty),
        .count (depth)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext     = state;
        ack           = 1'b0;
        stackPush     = 1'b0;
        stackPop      = 1'b0;
        gieClear      = 1'b0;
        pcLoad        = 1'b0;
        busy          = (state != IDLE);
        targetLoad    = 1'b0;
        targetNext    = targetReg;
        faultSet      = 1'b0;
        faultClr      = 1'b0;
        faultCodeNext = FAULT_NONE;
        depthInc      = 1'b0;
        depthDec      = 1'b0;

        case (state)
            IDLE: begin
                if (!stall && (intReq || callReq)) begin
                    ack  = 1'b1;
                    busy = 1'b1;
                    if (depthFull) begin
                        faultSet      = 1'b1;
                        faultCodeNext = FAULT_OVERFLOW;
                        stateNext     = FAULT;
                    end else begin
                        // Interrupt wins over a concurrent CALL; the CALL stays pending.
                        stackPush  = 1'b1;
                        depthInc   = 1'b1;
                        targetLoad = 1'b1;
                        targetNext = intReq ? INT_VECTOR : callTarget;
                        gieClear   = intReq;
                        stateNext  = LOAD;
                    end
                end else if (!stall && retReq) begin
                    ack  = 1'b1;
                    busy = 1'b1;
                    if (depthEmpty) begin
                        faultSet      = 1'b1;
                        faultCodeNext = FAULT_UNDERFLOW;
                        stateNext     = FAULT;
                    end else begin
                        stackPop  = 1'b1;
                        depthDec  = 1'b1;
                        stateNext = POP_WAIT;
                    end
                end
            end
            POP_WAIT: begin
                // RAM read data arrives the cycle after the pop strobe.
                targetLoad = 1'b1;
                targetNext = stackData;
                stateNext  = LOAD;
            end
            LOAD: begin
                pcLoad = 1'b1;
                if (!stall) begin
                    stateNext = IDLE;
                end
            end
            FAULT: begin
                if (clearFault) begin
                    faultClr  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            targetReg <= '0;
        end else if (targetLoad) begin
            targetReg <= targetNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            faultReg     <= 1'b0;
            faultCodeReg <= FAULT_NONE;
        end else if (faultSet) begin
            faultReg     <= 1'b1;
            faultCodeReg <= faultCodeNext;
        end else if (faultClr) begin
            faultReg     <= 1'b0;
            faultCodeReg <= FAULT_NONE;
        end
    end

    assign stackPcIn  = stackPush ? retAddr : '0;
    assign pcTarget   = pcLoad ? targetReg : '0;
    assign stackFault = faultReg;
    assign faultCode  = faultCodeReg;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl: inputs change 1ns after the rising edge, outputs checked 2ns after it.
module tb_call_stack_ctrl;

    logic        clk;
    logic        reset;
    logic        intReq;
    logic        callReq;
    logic        retReq;
    logic [12:0] retAddr;
    logic [12:0] callTarget;
    logic        stall;
    logic        clearFault;
    logic [12:0] stackData;
    logic        ack;
    logic        stackPush;
    logic        stackPop;
    logic [12:0] stackPcIn;
    logic        pcLoad;
    logic [12:0] pcTarget;
    logic        gieClear;
    logic        busy;
    logic        stackFault;
    logic [1:0]  faultCode;
    logic [3:0]  depth;

    int assertCount = 0;
    int failCount   = 0;

    call_stack_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .intReq     (intReq),
        .callReq    (callReq),
        .retReq     (retReq),
        .retAddr    (retAddr),
        .callTarget (callTarget),
        .stall      (stall),
        .clearFault (clearFault),
        .stackData  (stackData),
        .ack        (ack),
        .stackPush  (stackPush),
        .stackPop   (stackPop),
        .stackPcIn  (stackPcIn),
        .pcLoad     (pcLoad),
        .pcTarget   (pcTarget),
        .gieClear   (gieClear),
        .busy       (busy),
        .stackFault (stackFault),
        .faultCode  (faultCode),
        .depth      (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doCall(input logic [12:0] tgt, input logic [12:0] ra);
        callReq = 1'b1; callTarget = tgt; retAddr = ra;
        step();
        callReq = 1'b0;
        step();
    endtask

    task automatic doRet(input logic [12:0] popVal);
        retReq = 1'b1;
        step();
        retReq = 1'b0; stackData = popVal;
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int loadCount;
        reset = 1'b0; intReq = 1'b0; callReq = 1'b0; retReq = 1'b0;
        retAddr = '0; callTarget = '0; stall = 1'b0; clearFault = 1'b0; stackData = '0;
        repeat (3) @(posedge clk);
        #2;
        checkVal("rst_depth", depth, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_pcLoad", pcLoad, 0);
        checkVal("rst_fault", {stackFault, faultCode}, 0);
        checkVal("rst_pcTarget", pcTarget, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single CALL
        step();
        callReq = 1'b1; callTarget = 13'h0120; retAddr = 13'h0011;
        #1;
        checkVal("call_ack", {ack, stackPush, stackPop, busy}, 4'b1101);
        checkVal("call_pcIn", stackPcIn, 13'h0011);
        checkVal("call_noLoad", pcLoad, 0);
        step();
        callReq = 1'b0;
        #1;
        checkVal("call_load", {pcLoad, ack, busy}, 3'b101);
        checkVal("call_target", pcTarget, 13'h0120);
        checkVal("call_depth", depth, 1);
        step(); #1;
        checkVal("call_idle", {busy, pcLoad}, 2'b00);

        // RET returning to 0x0011
        retReq = 1'b1;
        #1;
        checkVal("ret_ack", {ack, stackPop, stackPush, busy}, 4'b1101);
        step();
        retReq = 1'b0; stackData = 13'h0011;
        #1;
        checkVal("ret_popwait", {pcLoad, busy, stackPop}, 3'b010);
        checkVal("ret_depth", depth, 0);
        step();
        stackData = 13'h1FFF;
        #1;
        checkVal("ret_load", pcLoad, 1);
        checkVal("ret_target", pcTarget, 13'h0011);
        step(); #1;
        checkVal("ret_idle", busy, 0);

        // INT > CALL > RET priority at depth 3
        doCall(13'h0100, 13'h0001);
        doCall(13'h0101, 13'h0002);
        doCall(13'h0102, 13'h0003);
        checkVal("pri_depth3", depth, 3);
        intReq = 1'b1; callReq = 1'b1; retReq = 1'b1;
        callTarget = 13'h0200; retAddr = 13'h0033;
        #1;
        checkVal("int_strobes", {ack, gieClear, stackPush, stackPop}, 4'b1110);
        checkVal("int_pcIn", stackPcIn, 13'h0033);
        step();
        intReq = 1'b0;
        #1;
        checkVal("int_load", {pcLoad, ack, gieClear}, 3'b100);
        checkVal("int_target", pcTarget, 13'h0004);
        checkVal("int_depth", depth, 4);
        step(); #1;
        checkVal("int_then_call", {ack, gieClear, stackPush, stackPop}, 4'b1010);
        step();
        callReq = 1'b0; retReq = 1'b0;
        #1;
        checkVal("int_call_target", pcTarget, 13'h0200);
        checkVal("int_call_depth", depth, 5);
        step();

        // Fill to DEPTH then overflow
        doCall(13'h0300, 13'h0010);
        doCall(13'h0301, 13'h0011);
        doCall(13'h0302, 13'h0012);
        checkVal("ovf_full", depth, 8);
        callReq = 1'b1; callTarget = 13'h0400;
        #1;
        checkVal("ovf_accept", {ack, stackPush, busy}, 3'b101);
        step();
        callReq = 1'b0;
        #1;
        checkVal("ovf_code", {stackFault, faultCode}, 3'b101);
        checkVal("ovf_hold", {busy, pcLoad, stackPush, stackPop}, 4'b1000);
        checkVal("ovf_depth", depth, 8);
        step(); #1;
        checkVal("ovf_busy", busy, 1);
        clearFault = 1'b1;
        step();
        clearFault = 1'b0;
        #1;
        checkVal("ovf_clear", {busy, stackFault, faultCode}, 4'b0000);
        checkVal("ovf_clear_depth", depth, 8);

        // Drain, then underflow
        for (int i = 0; i < 8; i++) doRet(13'h0050);
        checkVal("unf_empty", depth, 0);
        retReq = 1'b1;
        #1;
        checkVal("unf_accept", {ack, stackPop}, 2'b10);
        step();
        retReq = 1'b0;
        #1;
        checkVal("unf_code", {stackFault, faultCode}, 3'b110);
        checkVal("unf_depth", depth, 0);
        clearFault = 1'b1;
        step();
        clearFault = 1'b0;
        #1;
        checkVal("unf_clear", {busy, stackFault, faultCode}, 4'b0000);

        // stall blocks acceptance, then holds LOAD
        stall = 1'b1; callReq = 1'b1; callTarget = 13'h0155; retAddr = 13'h0077;
        #1;
        checkVal("stall_noack", {ack, stackPush, busy}, 3'b000);
        step();
        stall = 1'b0;
        #1;
        checkVal("stall_release_ack", ack, 1);
        step();
        callReq = 1'b0; stall = 1'b1;
        loadCount = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (pcLoad) loadCount++;
            step();
        end
        stall = 1'b0;
        #1;
        if (pcLoad) loadCount++;
        checkVal("stall_target", pcTarget, 13'h0155);
        step(); #1;
        checkVal("stall_load_cycles", loadCount, 4);
        checkVal("stall_idle", {busy, pcLoad}, 2'b00);

        // Reset during POP_WAIT
        retReq = 1'b1;
        step();
        retReq = 1'b0; stackData = 13'h0077;
        #1;
        checkVal("mid_popwait", {busy, pcLoad}, 2'b10);
        reset = 1'b0;
        #1;
        checkVal("mid_rst_outs", {ack, stackPush, stackPop, pcLoad, gieClear, busy, stackFault, faultCode}, 0);
        checkVal("mid_rst_depth", depth, 0);
        step();
        reset = 1'b1;
        loadCount = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (pcLoad || busy) loadCount++;
            step();
        end
        checkVal("mid_no_load", loadCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
